cordic_seq_ctrl: RTL and testbench

Parametrised sequencer for the iterative CORDIC datapath, the next generation of the fixed 16-iteration controller. It has a configurable iteration count and drives the iteration index to the shifter/arctan LUT. It also latches the operating mode (rotation/vectoring), generates the per-iteration direction bit, and holds the result with a fin/ack handshake. Sits between the host-side start logic and the x/y/z datapath registers.

---
 rtl/cordic_seq_ctrl_if.sv | 31 +++
 rtl/cordic_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_cordic_seq_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_seq_ctrl_if.sv
// Handshake/control bundle between the CORDIC sequencer and its neighbours.
// master: host start logic plus datapath sign taps (drives bgn, mode_in,
//         sgn_z, sgn_y, abrt, ack; observes the sequencer outputs).
// slave : the sequencer itself (drives itr, init, ld, dir, mode, busy, fin).
interface cordic_seq_ctrl_if #(
  parameter int ITRW = 4
);
  logic            bgn;
  logic            mode_in;
  logic            sgn_z;
  logic            sgn_y;
  logic            abrt;
  logic            ack;
  logic [ITRW-1:0] itr;
  logic            init;
  logic            ld;
  logic            dir;
  logic            mode;
  logic            busy;
  logic            fin;

  modport master (
    output bgn, mode_in, sgn_z, sgn_y, abrt, ack,
    input  itr, init, ld, dir, mode, busy, fin
  );

  modport slave (
    input  bgn, mode_in, sgn_z, sgn_y, abrt, ack,
    output itr, init, ld, dir, mode, busy, fin
  );
endinterface

// File: rtl/cordic_seq_ctrl.sv
// Iteration sequencer for the iterative CORDIC datapath.
// Runs NITR micro-rotations per operation, presents the iteration index to the
// shifter/arctan LUT, latches rotation/vectoring mode, derives the per-step
// direction bit from the datapath sign taps and holds the result with fin/ack.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-high reset
//   bus  - slave side of cordic_seq_ctrl_if
//          in : bgn, mode_in, sgn_z, sgn_y, abrt, ack
//          out: itr, init, ld, dir, mode, busy, fin
module cordic_seq_ctrl #(
  parameter int ITRW = 4,
  parameter int NITR = 16
) (
  input logic              clk,
  input logic              rst,
  cordic_seq_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Terminal compare on NITR-1 so NITR = 2^ITRW never relies on wrap-around.
  localparam logic [ITRW-1:0] ITR_LAST = ITRW'(NITR - 1);

  logic [1:0]      state;
  logic [ITRW-1:0] itr;
  logic            mode;
  logic            start;
  logic            init;
  logic            ld;
  logic            dir;
  logic            busy;
  logic            fin;

  // Output decode: depends on state and bgn/ack/abrt/sign taps only, never on
  // mode_in. rst forces everything low so a bgn held during reset is not seen.
  always_comb begin
    start = 1'b0;
    init  = 1'b0;
    ld    = 1'b0;
    dir   = 1'b0;
    busy  = 1'b0;
    fin   = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          start = bus.bgn & ~bus.abrt;
          init  = start;
          ld    = start;
        end
        S_EXEC: begin
          busy = 1'b1;
          ld   = ~bus.abrt;
          // Rotation drives z toward zero, vectoring drives y toward zero.
          dir  = mode ? bus.sgn_y : ~bus.sgn_z;
        end
        S_DONE: begin
          busy  = 1'b1;
          fin   = ~bus.abrt;
          start = bus.ack & bus.bgn & ~bus.abrt;
          init  = start;
          ld    = start;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      itr   <= '0;
      mode  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode  <= bus.mode_in;
            itr   <= '0;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (bus.abrt) begin
            itr   <= '0;
            state <= S_IDLE;
          end else if (itr == ITR_LAST) begin
            state <= S_DONE;
          end else begin
            itr <= itr + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.abrt) begin
            itr   <= '0;
            state <= S_IDLE;
          end else if (start) begin
            // Back-to-back: result consumed and next operation launched together.
            mode  <= bus.mode_in;
            itr   <= '0;
            state <= S_EXEC;
          end else if (bus.ack) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.itr  = itr;
  assign bus.mode = mode;
  assign bus.init = init;
  assign bus.ld   = ld;
  assign bus.dir  = dir;
  assign bus.busy = busy;
  assign bus.fin  = fin;

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Directed bench for cordic_seq_ctrl: three instances (NITR = 16, 8, 1) share
// clk/rst. Inputs change on the falling edge, outputs are sampled 1 ns later.
// Operations on the NITR=16 instance are logged in a scoreboard with their
// expected mode and the cycle in which fin must first rise.
module tb_cordic_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_seq_ctrl_if #(.ITRW(4)) if16 ();
  cordic_seq_ctrl_if #(.ITRW(4)) if8 ();
  cordic_seq_ctrl_if #(.ITRW(4)) if1 ();

  cordic_seq_ctrl #(.ITRW(4), .NITR(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));
  cordic_seq_ctrl #(.ITRW(4), .NITR(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
  cordic_seq_ctrl #(.ITRW(4), .NITR(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));

  typedef struct {
    logic mode;
    int   due;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Record a launch on the NITR=16 instance; fin must rise NITR+1 edges later.
  task automatic push16(input logic m);
    exp_t e;
    e.mode = m;
    e.due  = cyc + 17;
    sb.push_back(e);
  endtask

  task automatic expect_fin16(input int budget);
    int   n;
    exp_t e;
    n = 0;
    do begin
      step(); #1;
      n++;
    end while (!if16.fin && n < budget);
    chk("fin16_seen", if16.fin, 1);
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL sb_empty: observed fin with no pending operation, expected none");
    end else begin
      e = sb.pop_front();
      chk("fin16_latency", cyc, e.due);
      chk("fin16_mode", if16.mode, e.mode);
      chk("fin16_itr", if16.itr, 15);
      chk("fin16_ld", if16.ld, 0);
    end
  endtask

  initial begin
    logic ez;
    int   nfin;

    rst = 1'b1;
    {if16.bgn, if16.mode_in, if16.sgn_z, if16.sgn_y, if16.abrt, if16.ack} = '0;
    {if8.bgn,  if8.mode_in,  if8.sgn_z,  if8.sgn_y,  if8.abrt,  if8.ack}  = '0;
    {if1.bgn,  if1.mode_in,  if1.sgn_z,  if1.sgn_y,  if1.abrt,  if1.ack}  = '0;

    // Reset: bgn held during reset must not leak to init/ld.
    step(); if16.bgn = 1'b1; #1;
    chk("rst_init", if16.init, 0);
    chk("rst_ld", if16.ld, 0);
    chk("rst_busy", if16.busy, 0);
    chk("rst_fin", if16.fin, 0);
    chk("rst_itr", if16.itr, 0);
    chk("rst_mode", if16.mode, 0);
    step(); rst = 1'b0; if16.bgn = 1'b0; #1;
    chk("post_rst_outs", {if16.init, if16.ld, if16.dir, if16.busy, if16.fin}, 0);

    // Nominal rotation, sgn_z toggling.
    step(); if16.bgn = 1'b1; if16.mode_in = 1'b0; #1;
    chk("rot_init", if16.init, 1);
    chk("rot_ld0", if16.ld, 1);
    chk("rot_busy0", if16.busy, 0);
    push16(1'b0);
    for (int k = 0; k < 16; k++) begin
      step(); if16.bgn = 1'b0; if16.sgn_z = k[0]; if16.sgn_y = ~k[0]; #1;
      ez = ~k[0];
      chk("rot_itr", if16.itr, k);
      chk("rot_ld", if16.ld, 1);
      chk("rot_initlow", if16.init, 0);
      chk("rot_dir", if16.dir, ez);
      chk("rot_fin", if16.fin, 0);
    end
    expect_fin16(4);
    // Hold without ack; bgn ignored.
    for (int k = 0; k < 3; k++) begin
      step(); if16.bgn = 1'b1; #1;
      chk("hold_fin", if16.fin, 1);
      chk("hold_init", if16.init, 0);
      chk("hold_itr", if16.itr, 15);
    end
    step(); if16.bgn = 1'b0; if16.ack = 1'b1; #1;
    chk("ack_busy", if16.busy, 1);
    step(); if16.ack = 1'b0; #1;
    chk("after_ack_busy", if16.busy, 0);
    chk("after_ack_fin", if16.fin, 0);

    // Back-to-back: launch rotation, then ack+bgn together launching vectoring.
    step(); if16.bgn = 1'b1; if16.mode_in = 1'b0; #1;
    push16(1'b0);
    step(); if16.bgn = 1'b0;
    expect_fin16(20);
    if16.ack = 1'b1; if16.bgn = 1'b1; if16.mode_in = 1'b1; #1;
    chk("b2b_init", if16.init, 1);
    chk("b2b_ld", if16.ld, 1);
    push16(1'b1);
    step(); if16.ack = 1'b0; if16.bgn = 1'b0; if16.mode_in = 1'b0; #1;
    chk("b2b_fin_drop", if16.fin, 0);
    chk("b2b_itr0", if16.itr, 0);
    chk("b2b_mode", if16.mode, 1);
    expect_fin16(20);
    step(); if16.ack = 1'b1; #1;
    step(); if16.ack = 1'b0; #1;
    chk("b2b_idle", if16.busy, 0);

    // Abort in EXEC at itr = 3: no fin afterwards.
    step(); if16.bgn = 1'b1; #1;
    for (int k = 0; k < 3; k++) begin
      step(); if16.bgn = 1'b0; #1;
    end
    step(); if16.abrt = 1'b1; #1;
    chk("abrt_itr", if16.itr, 3);
    chk("abrt_ld", if16.ld, 0);
    chk("abrt_fin", if16.fin, 0);
    step(); if16.abrt = 1'b0; #1;
    chk("abrt_idle", if16.busy, 0);
    chk("abrt_itr0", if16.itr, 0);
    nfin = 0;
    for (int k = 0; k < 20; k++) begin
      step(); #1;
      if (if16.fin) nfin++;
    end
    chk("abrt_no_fin", nfin, 0);

    // Abort together with bgn in IDLE: no start.
    step(); if16.bgn = 1'b1; if16.abrt = 1'b1; #1;
    chk("abrt_idle_init", if16.init, 0);
    chk("abrt_idle_ld", if16.ld, 0);
    step(); if16.bgn = 1'b0; if16.abrt = 1'b0; #1;
    chk("abrt_idle_nostart", if16.busy, 0);

    // Abort in DONE without ack.
    step(); if16.bgn = 1'b1; if16.mode_in = 1'b1; #1;
    push16(1'b1);
    step(); if16.bgn = 1'b0;
    expect_fin16(20);
    step(); if16.abrt = 1'b1; #1;
    chk("abrt_done_fin", if16.fin, 0);
    step(); if16.abrt = 1'b0; #1;
    chk("abrt_done_busy", if16.busy, 0);
    chk("abrt_done_fin2", if16.fin, 0);

    // Asynchronous reset mid-EXEC, then clean restart.
    step(); if16.bgn = 1'b1; if16.mode_in = 1'b1; #1;
    for (int k = 0; k < 5; k++) begin
      step(); if16.bgn = 1'b0; #1;
    end
    rst = 1'b1; #1;
    chk("rst_mid_itr", if16.itr, 0);
    chk("rst_mid_busy", if16.busy, 0);
    chk("rst_mid_ld", if16.ld, 0);
    chk("rst_mid_fin", if16.fin, 0);
    chk("rst_mid_mode", if16.mode, 0);
    step(); rst = 1'b0; #1;
    step(); if16.bgn = 1'b1; if16.mode_in = 1'b0; #1;
    push16(1'b0);
    // bgn held high through EXEC: no restart, itr stops at 15.
    for (int k = 0; k < 16; k++) begin
      step(); #1;
      chk("held_bgn_init", if16.init, 0);
      chk("held_bgn_itr", if16.itr, k);
    end
    expect_fin16(4);
    step(); #1;
    chk("held_bgn_itr_nowrap", if16.itr, 15);
    chk("held_bgn_fin", if16.fin, 1);
    step(); if16.bgn = 1'b0; if16.ack = 1'b1; #1;
    step(); if16.ack = 1'b0; #1;
    chk("held_bgn_idle", if16.busy, 0);

    // Vectoring on NITR=8, mode_in changed mid-run.
    step(); if8.bgn = 1'b1; if8.mode_in = 1'b1; #1;
    chk("vec_init", if8.init, 1);
    for (int k = 0; k < 8; k++) begin
      step(); if8.bgn = 1'b0; if8.mode_in = 1'b0;
      if8.sgn_y = $urandom_range(0, 1); if8.sgn_z = $urandom_range(0, 1); #1;
      chk("vec_itr", if8.itr, k);
      chk("vec_mode", if8.mode, 1);
      chk("vec_dir", if8.dir, if8.sgn_y);
      chk("vec_ld", if8.ld, 1);
    end
    step(); #1;
    chk("vec_fin", if8.fin, 1);
    chk("vec_itr_done", if8.itr, 7);
    chk("vec_dir_done", if8.dir, 0);
    step(); if8.ack = 1'b1; #1;
    step(); if8.ack = 1'b0; #1;
    chk("vec_idle", if8.busy, 0);

    // NITR = 1: single EXEC cycle, fin in cycle 2.
    step(); if1.bgn = 1'b1; #1;
    chk("n1_init", if1.init, 1);
    step(); if1.bgn = 1'b0; #1;
    chk("n1_exec_ld", if1.ld, 1);
    chk("n1_exec_itr", if1.itr, 0);
    chk("n1_exec_fin", if1.fin, 0);
    step(); #1;
    chk("n1_fin", if1.fin, 1);
    chk("n1_itr", if1.itr, 0);
    step(); if1.ack = 1'b1; #1;
    step(); if1.ack = 1'b0; #1;
    chk("n1_idle", if1.busy, 0);

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
